// File: rtl/letreiro_rolagem_if.sv
// Control/display bus of the scrolling marquee sequencer.
// master: the controller side (drives run/pause/stop/direction, watches the display).
// slave : the sequencer (letreiro_rolagem).
// NUM_DISP must match the NUM_DISP of the sequencer it is connected to.
interface letreiro_rolagem_if #(
   parameter int NUM_DISP = 4
);
   logic                    iniciar;
   logic                    pausar;
   logic                    parar;
   logic                    dir;
   logic [3*NUM_DISP-1:0]   codigos;
   logic [2:0]              pos;
   logic                    rodando;
   logic                    passo;

   modport master (
      output iniciar, pausar, parar, dir,
      input  codigos, pos, rodando, passo
   );

   modport slave (
      input  iniciar, pausar, parar, dir,
      output codigos, pos, rodando, passo
   );
endinterface

// File: rtl/letreiro_rolagem.sv
// Scrolling marquee sequencer: scrolls the 8-code message 0..7 across NUM_DISP
// 3-bit displays, one step every TICK_DIV clocks, under an IDLE/RUN/PAUSE FSM.
// Optional build macro LETREIRO_PISCA_EN: while paused the prescaler keeps
// running and each wrap toggles a blink flag that blanks all displays.

// One display: its code is the message offset plus the display index, mod 8.
module letreiro_digito #(
   parameter int K = 0
) (
   input  logic [2:0] pos,
   output logic [2:0] codigo
);
   assign codigo = pos + 3'(K);
endmodule

module letreiro_rolagem #(
   parameter int TICK_DIV = 50_000_000,
   parameter int NUM_DISP = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   letreiro_rolagem_if.slave bus
);
   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] ULT = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} estado_t;

   estado_t                     est;
   logic [PW-1:0]               presc;
   logic [2:0]                  pos;
   logic [2:0]                  pos_prox;
   logic                        passo;
   logic                        rodando;
   logic [NUM_DISP-1:0][2:0]    codigos;
   logic [NUM_DISP-1:0][2:0]    jan_atual;
   logic [NUM_DISP-1:0][2:0]    jan_prox;
`ifdef LETREIRO_PISCA_EN
   logic                        pisca;
`endif

   // Offset the message takes at the next step; dir only matters at the tick.
   always_comb begin
      pos_prox = bus.dir ? (pos - 3'd1) : (pos + 3'd1);
   end

   // Window for the current offset (hold / resume) and for the next offset
   // (tick), so codigos lands in the same cycle as pos.
   for (genvar k = 0; k < NUM_DISP; k++) begin : g_disp
      letreiro_digito #(.K(k)) u_atual (.pos(pos),      .codigo(jan_atual[k]));
      letreiro_digito #(.K(k)) u_prox  (.pos(pos_prox), .codigo(jan_prox[k]));
   end

   // FSM, prescaler, position and registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         est     <= IDLE;
         presc   <= '0;
         pos     <= '0;
         passo   <= 1'b0;
         rodando <= 1'b0;
         codigos <= '1;
`ifdef LETREIRO_PISCA_EN
         pisca   <= 1'b0;
`endif
      end else begin
         passo <= 1'b0;
         if (bus.parar) begin
            // stop beats everything, including a tick landing this cycle
            est     <= IDLE;
            presc   <= '0;
            pos     <= '0;
            rodando <= 1'b0;
            codigos <= '1;
`ifdef LETREIRO_PISCA_EN
            pisca   <= 1'b0;
`endif
         end else begin
            case (est)
               IDLE: begin
                  if (bus.iniciar) begin
                     est     <= RUN;
                     presc   <= '0;
                     rodando <= 1'b1;
                     codigos <= jan_atual;
                  end
               end
               RUN: begin
                  if (bus.pausar) begin
                     // prescaler left as is so resume finishes the current step
                     est     <= PAUSE;
                     rodando <= 1'b0;
                  end else if (presc == ULT) begin
                     presc   <= '0;
                     pos     <= pos_prox;
                     passo   <= 1'b1;
                     codigos <= jan_prox;
                  end else begin
                     presc   <= presc + 1'b1;
                  end
               end
               PAUSE: begin
                  if (bus.iniciar && !bus.pausar) begin
                     est     <= RUN;
                     rodando <= 1'b1;
                     codigos <= jan_atual;
`ifdef LETREIRO_PISCA_EN
                     pisca   <= 1'b0;
`endif
                  end else begin
`ifdef LETREIRO_PISCA_EN
                     if (presc == ULT) begin
                        presc   <= '0;
                        pisca   <= ~pisca;
                        codigos <= pisca ? jan_atual : '1;
                     end else begin
                        presc   <= presc + 1'b1;
                     end
`endif
                  end
               end
               default: est <= IDLE;
            endcase
         end
      end
   end

   assign bus.codigos = codigos;
   assign bus.pos     = pos;
   assign bus.rodando = rodando;
   assign bus.passo   = passo;
endmodule

// File: tb/tb_letreiro_rolagem.sv
// Bench for letreiro_rolagem (TICK_DIV=4, NUM_DISP=4). Expected {pos,codigos}
// of every step go into a queue; a monitor pops and compares on each passo.
module tb_letreiro_rolagem;
   localparam int TD = 4;
   localparam int ND = 4;

   typedef struct packed {
      logic [2:0]  pos;
      logic [11:0] cod;
   } esp_t;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_ok;
   esp_t fila[$];
   logic [11:0] win [8];

   letreiro_rolagem_if #(.NUM_DISP(ND)) bus ();

   letreiro_rolagem #(.TICK_DIV(TD), .NUM_DISP(ND)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_ok++;
      else $display("FAIL %s: got %0h expected %0h", nome, act, exp);
   endtask

   // Scoreboard monitor: every passo must match the next queued step.
   always @(negedge clk) begin
      if (rst_n && bus.passo === 1'b1) begin
         if (fila.size() == 0) begin
            n_chk++;
            $display("FAIL passo_inesperado: got passo at pos %0d, expected none", bus.pos);
         end else begin
            esp_t e;
            e = fila.pop_front();
            chk("step_pos", 32'(bus.pos), 32'(e.pos));
            chk("step_codigos", 32'(bus.codigos), 32'(e.cod));
         end
      end
   end

   // Count negedges until passo shows up; an expired bound is a failure.
   task automatic wait_passo(input string nome, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.passo !== 1'b1 && n < 60);
      if (bus.passo !== 1'b1) begin
         n_chk++;
         $display("FAIL %s timeout: got no passo in %0d clk, expected one", nome, n);
      end
   endtask

   task automatic push(input int p);
      esp_t e;
      e.pos = 3'(p);
      e.cod = win[p];
      fila.push_back(e);
   endtask

   initial begin
      int n;
      int seq_l [8];
      // hand-computed windows {d3,d2,d1,d0} for pos 0..7
      win[0] = 12'h688; win[1] = 12'h8D1; win[2] = 12'hB1A; win[3] = 12'hD63;
      win[4] = 12'hFAC; win[5] = 12'h1F5; win[6] = 12'h23E; win[7] = 12'h447;
      seq_l = '{1, 2, 3, 4, 5, 6, 7, 0};
      n_chk = 0;
      n_ok  = 0;
      rst_n = 1'b0;
      bus.iniciar = 1'b0;
      bus.pausar  = 1'b0;
      bus.parar   = 1'b0;
      bus.dir     = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_codigos", 32'(bus.codigos), 32'h0FFF);
      chk("reset_pos", 32'(bus.pos), 0);
      chk("reset_rodando", 32'(bus.rodando), 0);
      chk("reset_passo", 32'(bus.passo), 0);
      rst_n = 1'b1;

      // pausar alone in IDLE is ignored
      bus.pausar = 1'b1;
      repeat (2) @(negedge clk);
      bus.pausar = 1'b0;
      chk("idle_pausar_rodando", 32'(bus.rodando), 0);
      chk("idle_pausar_codigos", 32'(bus.codigos), 32'h0FFF);

      // leftward scroll over a full lap
      foreach (seq_l[i]) push(seq_l[i]);
      bus.iniciar = 1'b1;
      @(negedge clk);
      bus.iniciar = 1'b0;
      chk("run_rodando", 32'(bus.rodando), 1);
      chk("run_codigos_inicial", 32'(bus.codigos), 32'(win[0]));
      wait_passo("primeiro_passo", n);
      chk("primeiro_passo_lat", 32'(n), 4);
      for (int i = 1; i < 8; i++) begin
         wait_passo("passo_esq", n);
         chk("periodo_esq", 32'(n), 4);
      end

      // rightward: wrap 0 -> 7, then 6
      bus.dir = 1'b1;
      push(7);
      push(6);
      for (int i = 0; i < 2; i++) begin
         wait_passo("passo_dir", n);
         chk("periodo_dir", 32'(n), 4);
      end

      // pause with prescaler at 1, hold 10 clk, resume finishes the step
      @(negedge clk);
      bus.pausar = 1'b1;
      repeat (10) @(negedge clk);
      bus.pausar = 1'b0;
      chk("pausa_rodando", 32'(bus.rodando), 0);
      chk("pausa_pos", 32'(bus.pos), 6);
      chk("pausa_codigos", 32'(bus.codigos), 32'(win[6]));
      push(5);
      bus.iniciar = 1'b1;
      wait_passo("retoma", n);
      bus.iniciar = 1'b0;
      chk("retoma_restante", 32'(n), 4);

      // parar on the tick cycle wins
      repeat (3) @(negedge clk);
      bus.parar = 1'b1;
      @(negedge clk);
      bus.parar = 1'b0;
      chk("parar_tick_passo", 32'(bus.passo), 0);
      chk("parar_tick_pos", 32'(bus.pos), 0);
      chk("parar_tick_codigos", 32'(bus.codigos), 32'h0FFF);
      chk("parar_tick_rodando", 32'(bus.rodando), 0);

      // all three requests together in RUN -> IDLE
      bus.dir = 1'b0;
      bus.iniciar = 1'b1;
      @(negedge clk);
      bus.iniciar = 1'b0;
      @(negedge clk);
      bus.iniciar = 1'b1;
      bus.pausar  = 1'b1;
      bus.parar   = 1'b1;
      @(negedge clk);
      bus.iniciar = 1'b0;
      bus.pausar  = 1'b0;
      bus.parar   = 1'b0;
      chk("tres_rodando", 32'(bus.rodando), 0);
      chk("tres_codigos", 32'(bus.codigos), 32'h0FFF);
      repeat (6) @(negedge clk);
      chk("tres_idle_pos", 32'(bus.pos), 0);

      // asynchronous reset in the middle of RUN
      push(1);
      bus.iniciar = 1'b1;
      @(negedge clk);
      bus.iniciar = 1'b0;
      wait_passo("antes_reset", n);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_codigos", 32'(bus.codigos), 32'h0FFF);
      chk("rst_async_pos", 32'(bus.pos), 0);
      chk("rst_async_rodando", 32'(bus.rodando), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      chk("fila_vazia", 32'(fila.size()), 0);
      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end
endmodule
